comp_mac: RTL and testbench
===========================

Name: comp_mac

Overview:
- Pipelined unsigned multiply-accumulate unit.
- On each enabled cycle it multiplies two p_size-bit operands and outputs the full-width product.
- It also outputs a running, wrapping sum of all products since reset, with a one-cycle data-valid strobe.
- Sits in a datapath as a streaming arithmetic element driven by an upstream producer that asserts ena per sample.

Parameters:
p_size, 1, operand width in bits (>=1); product and accumulator are 2*p_size bits.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset (0 = reset asserted)
i_param  input  p_size  operand A, unsigned
i_param_2  input  p_size  operand B, unsigned
ena  input  1  sample strobe; operands valid when high
o_param  output  2*p_size  registered product A*B of the sample
o_param_2  output  2*p_size  registered running accumulator (sum of all products, mod 2^(2*p_size))
dv  output  1  one-cycle pulse marking o_param/o_param_2 as updated

Behaviour:
- Reset (rst=0, asynchronous): all pipeline registers, o_param, o_param_2 and dv go to 0 immediately; held while rst=0. Release is synchronous in effect: first capture on the first rising edge with rst=1.
- Stage 1 (edge N):
  - ena=1: capture i_param, i_param_2 into operand registers and set v1=1.
  - ena=0: v1=0 and operand registers hold.
  - i_param/i_param_2 are don't-care when ena=0.
- Stage 2 (edge N+1), when v1=1:
  - o_param <= opA*opB (full 2*p_size-bit unsigned product, no truncation possible).
  - o_param_2 <= o_param_2 + opA*opB, truncated to 2*p_size bits (wrap-around, no saturation, no overflow flag).
  - dv <= 1.
- Stage 2, when v1=0: dv <= 0; o_param and o_param_2 hold their last values.
- Latency: ena sampled high at edge N -> dv high and results valid after edge N+1 (2 edges), for exactly one cycle per sample.
- Throughput: one sample per cycle. Back-to-back ena keeps dv high continuously, with o_param/o_param_2 updating every cycle.
- Zero operands: product 0, dv still pulses, accumulator unchanged in value.
- Reset mid-operation: in-flight sample discarded, accumulator cleared, dv low; no result emerges after release unless ena is reasserted.
- Product computed combinationally from stage-1 registers; no multicycle paths.
- Operands and results strictly unsigned.

Decomposition:
- Package comp_mac_pkg: function/constant deriving the result width (2*p_size) and the reset constants (zero vectors).
- One natural sub-module, comp_mac_stage: the registered operand-capture stage (data plus valid bit, ena-gated, async active-low reset).
- Product/accumulate logic stays in the top.

Test Plan:
1. p_size=4. Hold rst=0 for 3 cycles with random inputs and ena=1 -> o_param=0, o_param_2=0, dv=0 throughout. Then assert rst=0 asynchronously mid-cycle after activity -> outputs clear without waiting for an edge.
2. p_size=4, single sample A=3, B=5, ena=1 for one cycle -> two edges later dv=1 for one cycle, o_param=15, o_param_2=15. Afterwards dv=0 and the values hold.
3. p_size=4, back-to-back (3,5), (15,15), (2,8) -> dv high 3 consecutive cycles; o_param=15, 225, 16; o_param_2=15, 240, 0 (wrap mod 256).
4. p_size=4, ena=0 with toggling inputs for 5 cycles between samples -> no dv, outputs unchanged. Next sample (1,1) -> o_param=1, o_param_2 increments by 1.
5. p_size=1 (default), samples (1,1), (1,0), (1,1) -> o_param=1, 0, 1; o_param_2=1, 1, 2 (2-bit field); dv pulses for each, including the zero product.
6. p_size=4, assert rst=0 one cycle after ena (sample in flight), release -> no dv pulse, o_param=0, o_param_2=0. Subsequent sample (4,4) -> o_param=16, o_param_2=16.

Source files
------------

// File: rtl/comp_mac_pkg.sv
// Shared definitions for the comp_mac multiply-accumulate unit:
// result-width derivation and reset constants.
package comp_mac_pkg;

   // Product and accumulator are twice the operand width, so an unsigned
   // product can never overflow its field.
   function automatic int res_width(input int p_size);
      return 2 * p_size;
   endfunction

   // Reset value of every valid/strobe bit in the pipeline.
   localparam logic VALID_RST = 1'b0;

   // Reset value of every data bit in the pipeline (replicated to width).
   localparam logic DATA_RST_BIT = 1'b0;

endpackage

// File: rtl/comp_mac_stage.sv
// Operand capture stage: registers both operands and a valid bit when ena
// is high. Operands hold while ena is low; only the valid bit drops.
module comp_mac_stage
   import comp_mac_pkg::*;
#(
   parameter int p_size = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [p_size-1:0] i_a,
   input  logic [p_size-1:0] i_b,
   output logic [p_size-1:0] o_a,
   output logic [p_size-1:0] o_b,
   output logic              o_v
);

   logic [p_size-1:0] a_q, a_d;
   logic [p_size-1:0] b_q, b_d;
   logic              v_q, v_d;

   // Next-state: capture operands on ena, otherwise hold; valid follows ena.
   always_comb begin
      a_d = a_q;
      b_d = b_q;
      v_d = ena;
      if (ena) begin
         a_d = i_a;
         b_d = i_b;
      end
   end

   // Stage registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q <= {p_size{DATA_RST_BIT}};
         b_q <= {p_size{DATA_RST_BIT}};
         v_q <= VALID_RST;
      end else begin
         a_q <= a_d;
         b_q <= b_d;
         v_q <= v_d;
      end
   end

   assign o_a = a_q;
   assign o_b = b_q;
   assign o_v = v_q;

endmodule

// File: rtl/comp_mac.sv
// Pipelined unsigned multiply-accumulate. Stage 1 captures operands; stage 2
// registers the full-width product and a wrapping running sum of products.
//
// Handshake: ena is a one-way sample strobe from the producer (no ready, no
// backpressure; one sample per cycle is always accepted). dv is a one-way
// valid strobe: it is high for exactly one cycle per accepted sample, two
// rising edges after ena was sampled high, and o_param/o_param_2 are valid
// in that cycle and hold their values afterwards.
module comp_mac
   import comp_mac_pkg::*;
#(
   parameter int p_size = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [p_size-1:0]             i_param,
   input  logic [p_size-1:0]             i_param_2,
   input  logic                          ena,
   output logic [res_width(p_size)-1:0]  o_param,
   output logic [res_width(p_size)-1:0]  o_param_2,
   output logic                          dv
);

   localparam int W = res_width(p_size);
   localparam logic [W-1:0] RES_RST = {W{DATA_RST_BIT}};

   logic [p_size-1:0] op_a;
   logic [p_size-1:0] op_b;
   logic              v1;

   logic [W-1:0] prod;
   logic [W-1:0] prod_q, prod_d;
   logic [W-1:0] acc_q, acc_d;
   logic         dv_q, dv_d;

   comp_mac_stage #(
      .p_size (p_size)
   ) u_stage (
      .clk (clk),
      .rst (rst),
      .ena (ena),
      .i_a (i_param),
      .i_b (i_param_2),
      .o_a (op_a),
      .o_b (op_b),
      .o_v (v1)
   );

   // Full-width product of the captured operands; zero-extend first so the
   // multiply is evaluated at the result width.
   always_comb begin
      prod = {{p_size{1'b0}}, op_a} * {{p_size{1'b0}}, op_b};
   end

   // Stage-2 next state: update product and accumulator only for valid samples.
   always_comb begin
      prod_d = prod_q;
      acc_d  = acc_q;
      dv_d   = v1;
      if (v1) begin
         prod_d = prod;
         acc_d  = acc_q + prod;
      end
   end

   // Result registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_q <= RES_RST;
         acc_q  <= RES_RST;
         dv_q   <= VALID_RST;
      end else begin
         prod_q <= prod_d;
         acc_q  <= acc_d;
         dv_q   <= dv_d;
      end
   end

   assign o_param   = prod_q;
   assign o_param_2 = acc_q;
   assign dv        = dv_q;

endmodule

// File: tb/tb_comp_mac.sv
// Directed testbench for comp_mac: a 4-bit instance for most scenarios and
// a default 1-bit instance for the narrow-width case.
module tb_comp_mac;

   logic       clk;
   logic       rst;

   // p_size = 4 instance
   logic [3:0] a;
   logic [3:0] b;
   logic       ena;
   logic [7:0] o_prod;
   logic [7:0] o_acc;
   logic       dv;

   // p_size = 1 instance
   logic [0:0] a1;
   logic [0:0] b1;
   logic       ena1;
   logic [1:0] o_prod1;
   logic [1:0] o_acc1;
   logic       dv1;

   int checks;
   int errors;

   comp_mac #(.p_size(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .i_param   (a),
      .i_param_2 (b),
      .ena       (ena),
      .o_param   (o_prod),
      .o_param_2 (o_acc),
      .dv        (dv)
   );

   comp_mac u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .i_param   (a1),
      .i_param_2 (b1),
      .ena       (ena1),
      .o_param   (o_prod1),
      .o_param_2 (o_acc1),
      .dv        (dv1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pulse_reset();
      @(negedge clk);
      rst = 1'b0; ena = 1'b0; ena1 = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      logic [16:0] exp;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); ena = 1'b1;
         a1 = 1'($urandom_range(0, 1)); b1 = 1'($urandom_range(0, 1)); ena1 = 1'b1;
         checks++;
         if ({dv, o_prod, o_acc} !== 17'd0) begin
            errors++;
            $display("FAIL reset_hold4 cyc%0d: got dv=%0b prod=%0d acc=%0d, want 0 0 0", i, dv, o_prod, o_acc);
         end
         checks++;
         if ({dv1, o_prod1, o_acc1} !== 5'd0) begin
            errors++;
            $display("FAIL reset_hold1 cyc%0d: got dv=%0b prod=%0d acc=%0d, want 0 0 0", i, dv1, o_prod1, o_acc1);
         end
      end
      // release and create activity, then clear asynchronously mid-cycle
      @(negedge clk);
      rst = 1'b1; a = 4'd3; b = 4'd5; ena = 1'b1; ena1 = 1'b0;
      @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      exp = {1'b1, 8'd15, 8'd15};
      checks++;
      if ({dv, o_prod, o_acc} !== exp) begin
         errors++;
         $display("FAIL pre_async_rst: got dv=%0b prod=%0d acc=%0d, want 1 15 15", dv, o_prod, o_acc);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({dv, o_prod, o_acc} !== 17'd0) begin
         errors++;
         $display("FAIL async_rst_clear: got dv=%0b prod=%0d acc=%0d, want 0 0 0", dv, o_prod, o_acc);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_single();
      logic [16:0] exp;
      @(negedge clk);
      a = 4'd3; b = 4'd5; ena = 1'b1;
      @(negedge clk);
      ena = 1'b0; a = 4'd9; b = 4'd9;
      checks++;
      if ({dv, o_prod, o_acc} !== 17'd0) begin
         errors++;
         $display("FAIL single_early: got dv=%0b prod=%0d acc=%0d, want 0 0 0", dv, o_prod, o_acc);
      end
      @(negedge clk);
      exp = {1'b1, 8'd15, 8'd15};
      checks++;
      if ({dv, o_prod, o_acc} !== exp) begin
         errors++;
         $display("FAIL single_result: got dv=%0b prod=%0d acc=%0d, want 1 15 15", dv, o_prod, o_acc);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         exp = {1'b0, 8'd15, 8'd15};
         checks++;
         if ({dv, o_prod, o_acc} !== exp) begin
            errors++;
            $display("FAIL single_hold%0d: got dv=%0b prod=%0d acc=%0d, want 0 15 15", i, dv, o_prod, o_acc);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] va [3];
      logic [3:0] vb [3];
      logic [7:0] ep [3];
      logic [7:0] ea [3];
      logic [16:0] exp;
      va = '{4'd3, 4'd15, 4'd2};
      vb = '{4'd5, 4'd15, 4'd8};
      ep = '{8'd15, 8'd225, 8'd16};
      ea = '{8'd15, 8'd240, 8'd0};
      pulse_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i < 3) begin
            a = va[i]; b = vb[i]; ena = 1'b1;
         end else begin
            ena = 1'b0;
         end
         if (i < 2)      exp = 17'd0;
         else if (i < 5) exp = {1'b1, ep[i-2], ea[i-2]};
         else            exp = {1'b0, 8'd16, 8'd0};
         checks++;
         if ({dv, o_prod, o_acc} !== exp) begin
            errors++;
            $display("FAIL b2b_step%0d: got dv=%0b prod=%0d acc=%0d, want dv=%0b prod=%0d acc=%0d",
                     i, dv, o_prod, o_acc, exp[16], exp[15:8], exp[7:0]);
         end
      end
   endtask

   task automatic test_idle();
      logic [16:0] exp;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         a = ~a; b = 4'($urandom_range(0, 15)); ena = 1'b0;
         exp = {1'b0, 8'd16, 8'd0};
         checks++;
         if ({dv, o_prod, o_acc} !== exp) begin
            errors++;
            $display("FAIL idle_cyc%0d: got dv=%0b prod=%0d acc=%0d, want 0 16 0", i, dv, o_prod, o_acc);
         end
      end
      @(negedge clk);
      a = 4'd1; b = 4'd1; ena = 1'b1;
      @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      exp = {1'b1, 8'd1, 8'd1};
      checks++;
      if ({dv, o_prod, o_acc} !== exp) begin
         errors++;
         $display("FAIL idle_then_sample: got dv=%0b prod=%0d acc=%0d, want 1 1 1", dv, o_prod, o_acc);
      end
   endtask

   task automatic test_width1();
      logic va [3];
      logic vb [3];
      logic [1:0] ep [3];
      logic [1:0] ea [3];
      logic [4:0] exp;
      va = '{1'b1, 1'b1, 1'b1};
      vb = '{1'b1, 1'b0, 1'b1};
      ep = '{2'd1, 2'd0, 2'd1};
      ea = '{2'd1, 2'd1, 2'd2};
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i < 3) begin
            a1 = va[i]; b1 = vb[i]; ena1 = 1'b1;
         end else begin
            ena1 = 1'b0;
         end
         if (i < 2)      exp = 5'd0;
         else if (i < 5) exp = {1'b1, ep[i-2], ea[i-2]};
         else            exp = {1'b0, 2'd1, 2'd2};
         checks++;
         if ({dv1, o_prod1, o_acc1} !== exp) begin
            errors++;
            $display("FAIL w1_step%0d: got dv=%0b prod=%0d acc=%0d, want dv=%0b prod=%0d acc=%0d",
                     i, dv1, o_prod1, o_acc1, exp[4], exp[3:2], exp[1:0]);
         end
      end
   endtask

   task automatic test_reset_inflight();
      logic [16:0] exp;
      @(negedge clk);
      a = 4'd7; b = 4'd9; ena = 1'b1;
      @(negedge clk);
      ena = 1'b0;
      exp = {1'b0, 8'd1, 8'd1};
      checks++;
      if ({dv, o_prod, o_acc} !== exp) begin
         errors++;
         $display("FAIL inflight_pre: got dv=%0b prod=%0d acc=%0d, want 0 1 1", dv, o_prod, o_acc);
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({dv, o_prod, o_acc} !== 17'd0) begin
         errors++;
         $display("FAIL inflight_clear: got dv=%0b prod=%0d acc=%0d, want 0 0 0", dv, o_prod, o_acc);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({dv, o_prod, o_acc} !== 17'd0) begin
            errors++;
            $display("FAIL inflight_post%0d: got dv=%0b prod=%0d acc=%0d, want 0 0 0", i, dv, o_prod, o_acc);
         end
      end
      @(negedge clk);
      a = 4'd4; b = 4'd4; ena = 1'b1;
      @(negedge clk);
      ena = 1'b0;
      @(negedge clk);
      exp = {1'b1, 8'd16, 8'd16};
      checks++;
      if ({dv, o_prod, o_acc} !== exp) begin
         errors++;
         $display("FAIL inflight_next: got dv=%0b prod=%0d acc=%0d, want 1 16 16", dv, o_prod, o_acc);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      a = '0; b = '0; ena = 1'b0;
      a1 = '0; b1 = '0; ena1 = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_idle();
      test_width1();
      test_reset_inflight();
      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
